// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: timing sets, the total-period helper and RGB field positions.
package vga_pkg;

    typedef enum logic {
        MODE_640X480,
        MODE_800X600
    } vga_mode_e;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    // Both sets are the standard 60 Hz modes.
    function automatic vga_timing_t vga_timing(input vga_mode_e mode);
        vga_timing_t t;
        case (mode)
            MODE_800X600: t = '{h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
                                v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23};
            default:      t = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33};
        endcase
        return t;
    endfunction

    localparam vga_timing_t TIMING_640X480 = vga_timing(MODE_640X480);

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int RGB_R_MSB = 23;
    localparam int RGB_R_LSB = 16;
    localparam int RGB_G_MSB = 15;
    localparam int RGB_G_LSB = 8;
    localparam int RGB_B_MSB = 7;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel fetch bus between the timing generator (master) and the frame source (slave).
interface vga_timing_gen_if #(
    parameter int CNT_W = 12
);
    // addr_valid qualifies h_addr/v_addr for one cycle; there is no backpressure, and the
    // slave must return the matching vga_data exactly DATA_LAT cycles later, every cycle.
    logic [CNT_W-1:0] h_addr;
    logic [CNT_W-1:0] v_addr;
    logic             addr_valid;
    logic             line_start;
    logic             frame_start;
    logic [23:0]      vga_data;

    modport master (
        output h_addr, v_addr, addr_valid, line_start, frame_start,
        input  vga_data
    );

    modport slave (
        input  h_addr, v_addr, addr_valid, line_start, frame_start,
        output vga_data
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a common reset value; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge pclk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
            end else begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA scan generator: issues pixel addresses early, then aligns sync/de/RGB
// with the frame source's read latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = TIMING_640X480.h_active,
    parameter int H_FP      = TIMING_640X480.h_fp,
    parameter int H_SYNC    = TIMING_640X480.h_sync,
    parameter int H_BP      = TIMING_640X480.h_bp,
    parameter int V_ACTIVE  = TIMING_640X480.v_active,
    parameter int V_FP      = TIMING_640X480.v_fp,
    parameter int V_SYNC    = TIMING_640X480.v_sync,
    parameter int V_BP      = TIMING_640X480.v_bp,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int DATA_LAT  = 2,
    parameter int CNT_W     = 12
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              en,
    vga_timing_gen_if.master  pix,
    output logic [15:0]       frame_cnt,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_ON  = (HSYNC_POL != 0);
    localparam logic             VS_ON  = (VSYNC_POL != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [15:0]      frame_cnt_q;
    logic             scan_act;
    logic             addr_valid;
    logic             hs_raw;
    logic             vs_raw;
    logic             dl_hs;
    logic             dl_vs;
    logic             dl_av;

    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_cnt_q <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt       <= '0;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
                v_cnt <= v_cnt + CNT_W'(1);
            end
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;

    // Reset gates the address stage so nothing is requested while it is held.
    always_comb begin
        scan_act        = en & ~reset;
        addr_valid      = scan_act && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_raw          = scan_act && (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
        vs_raw          = scan_act && (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
        pix.addr_valid  = addr_valid;
        pix.h_addr      = addr_valid ? h_cnt : '0;
        pix.v_addr      = addr_valid ? v_cnt : '0;
        pix.line_start  = scan_act && (h_cnt == '0);
        pix.frame_start = scan_act && (h_cnt == '0) && (v_cnt == '0);
    end

    // Pipeline carries "active" flags; polarity is applied only at the pins.
    vga_delay_line #(
        .DEPTH   (DATA_LAT),
        .WIDTH   (3),
        .RST_VAL (3'b000)
    ) u_sync_dl (
        .pclk  (pclk),
        .reset (reset),
        .d     ({hs_raw, vs_raw, addr_valid}),
        .q     ({dl_hs, dl_vs, dl_av})
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            de    <= 1'b0;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            hsync <= dl_hs ? HS_ON : ~HS_ON;
            vsync <= dl_vs ? VS_ON : ~VS_ON;
            de    <= dl_av;
            vga_r <= dl_av ? pix.vga_data[RGB_R_MSB:RGB_R_LSB] : '0;
            vga_g <= dl_av ? pix.vga_data[RGB_G_MSB:RGB_G_LSB] : '0;
            vga_b <= dl_av ? pix.vga_data[RGB_B_MSB:RGB_B_LSB] : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 scan: directed phases plus random en/reset traffic.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int LAT = 2;
    localparam int CW  = 12;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;

    typedef struct packed {
        logic          av;
        logic [CW-1:0] ha;
        logic [CW-1:0] va;
        logic          ls;
        logic          fs;
        logic [15:0]   fc;
        logic          hs;
        logic          vs;
        logic          de;
        logic [23:0]   rgb;
    } exp_t;

    typedef struct packed {
        logic        av;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } stg_t;

    localparam int EXP_W = $bits(exp_t);

    logic              pclk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [15:0]       frame_cnt;
    logic              hsync, vsync, de;
    logic [7:0]        vga_r, vga_g, vga_b;
    logic [23:0]       src_d1, src_d2;

    logic [EXP_W-1:0]  exp_q[$];
    stg_t              hist[$];
    int                pos;
    logic [15:0]       fc_m;
    bit                forced;
    int                errors;
    int                checks;

    vga_timing_gen_if #(.CNT_W(CW)) pix ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .DATA_LAT(LAT), .CNT_W(CW)
    ) dut (
        .pclk      (pclk),
        .reset     (reset),
        .en        (en),
        .pix       (pix.master),
        .frame_cnt (frame_cnt),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b)
    );

    // clock / frame source with two cycles of read latency
    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        src_d1 <= {pix.v_addr[7:0], pix.h_addr[7:0], 8'hA5};
        src_d2 <= src_d1;
    end
    assign pix.vga_data = src_d2;

    // driver: one cycle of stimulus plus the reference model's expectation for that cycle
    task automatic step(input logic e, input logic r, input bit preload = 1'b0);
        exp_t x;
        stg_t s;
        stg_t o;
        int   h, v;
        bit   act;
        @(negedge pclk);
        if (forced) begin
            release dut.frame_cnt_q;
            forced = 1'b0;
        end
        en    = e;
        reset = r;
        if (preload) begin
            force dut.frame_cnt_q = 16'hFFFF;
            forced = 1'b1;
            fc_m   = 16'hFFFF;
        end
        h   = pos % HT;
        v   = pos / HT;
        act = e && !r;
        s.av  = act && (h < HA) && (v < VA);
        s.hs  = act && (h >= HA + HF) && (h < HA + HF + HS);
        s.vs  = act && (v >= VA + VF) && (v < VA + VF + VS);
        s.rgb = s.av ? {8'(v), 8'(h), 8'hA5} : 24'h0;
        x.av  = s.av;
        x.ha  = s.av ? CW'(h) : '0;
        x.va  = s.av ? CW'(v) : '0;
        x.ls  = act && (h == 0);
        x.fs  = act && (pos == 0);
        x.fc  = fc_m;
        hist.push_back(s);
        if (r) for (int i = 0; i <= LAT; i++) hist[hist.size() - 1 - i] = '0;
        o    = hist.pop_front();
        x.hs = ~o.hs;
        x.vs = ~o.vs;
        x.de = o.av;
        x.rgb = o.av ? o.rgb : 24'h0;
        exp_q.push_back(x);
        if (r) begin
            pos  = 0;
            fc_m = '0;
        end else if (e) begin
            pos = pos + 1;
            if (pos == HT * VT) begin
                pos  = 0;
                fc_m = fc_m + 16'd1;
            end
        end else begin
            pos = 0;
        end
    endtask

    // monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t x;
        forever begin
            @(negedge pclk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if ({pix.addr_valid, pix.h_addr, pix.v_addr, pix.line_start, pix.frame_start} !==
                    {x.av, x.ha, x.va, x.ls, x.fs}) begin
                    errors++;
                    $display("FAIL addr t=%0t: got av=%b h=%0d v=%0d ls=%b fs=%b, want av=%b h=%0d v=%0d ls=%b fs=%b",
                             $time, pix.addr_valid, pix.h_addr, pix.v_addr, pix.line_start, pix.frame_start,
                             x.av, x.ha, x.va, x.ls, x.fs);
                end
                checks++;
                if (frame_cnt !== x.fc) begin
                    errors++;
                    $display("FAIL frame_cnt t=%0t: got %h, want %h", $time, frame_cnt, x.fc);
                end
                checks++;
                if ({hsync, vsync} !== {x.hs, x.vs}) begin
                    errors++;
                    $display("FAIL sync t=%0t: got hs=%b vs=%b, want hs=%b vs=%b",
                             $time, hsync, vsync, x.hs, x.vs);
                end
                checks++;
                if ({de, vga_r, vga_g, vga_b} !== {x.de, x.rgb}) begin
                    errors++;
                    $display("FAIL video t=%0t: got de=%b rgb=%h, want de=%b rgb=%h",
                             $time, de, {vga_r, vga_g, vga_b}, x.de, x.rgb);
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        pos    = 0;
        fc_m   = '0;
        forced = 1'b0;
        for (int i = 0; i <= LAT; i++) hist.push_back('0);

        repeat (3) step(1'b0, 1'b1);
        // two complete frames and a little more
        repeat (2 * HT * VT + 5) step(1'b1, 1'b0);
        // drop en at h=5, then restart from the origin
        while (pos % HT != 5) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0);
        // one-cycle reset while hsync is active
        while (pos % HT != 11) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (40) step(1'b1, 1'b0);
        // frame counter wrap from 16'hFFFF
        while (pos % HT != 3) step(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        while (fc_m != 16'h0000) step(1'b1, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        // random en / reset traffic
        repeat (3000) step($urandom_range(0, 15) != 0, $urandom_range(0, 149) == 0);

        repeat (2) @(negedge pclk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
